// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - memory-mapped bus controller with region RAM ports and a control/status window
module mmio_controller #(
    parameter int                            ADDR_W      = 16,
    parameter int                            DATA_W      = 16,
    parameter int                            NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h4400, 16'h2400, 16'h2000, 16'h0000},
    parameter logic [ADDR_W-1:0]             CTRL_BASE   = 16'h4800,
    parameter int                            NUM_CTRL    = 4,
    parameter int                            RD_LAT      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               wdata,
    output logic [DATA_W-1:0]               rdata,
    output logic                            ack,
    output logic                            err,
    output logic                            busy,
    output logic [NUM_REGIONS-1:0]          reg_en,
    output logic                            reg_we,
    output logic [ADDR_W-1:0]               reg_addr,
    output logic [DATA_W-1:0]               reg_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0]   reg_rdata,
    input  logic                            hblank,
    input  logic                            vblank,
    output logic [NUM_CTRL*DATA_W-1:0]      ctrl_out,
    output logic                            irq
);

    localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CIDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] KIND_REGION = 2'd0;
    localparam logic [1:0] KIND_CTRL   = 2'd1;
    localparam logic [1:0] KIND_UNMAP  = 2'd2;

    // Region i spans BOUNDS[i] .. BOUNDS[i+1]-1; the control base closes the last region.
    localparam logic [(NUM_REGIONS+1)*ADDR_W-1:0] BOUNDS = {CTRL_BASE, REGION_BASE};
    localparam logic [ADDR_W-1:0] CTRL_SPAN = ADDR_W'(NUM_CTRL);
    localparam logic [1:0]        WAIT_LOAD = 2'(RD_LAT - 1);

    // Address decode results for the incoming request
    logic [1:0]        dec_kind;
    logic [RIDX_W-1:0] dec_ridx;
    logic [CIDX_W-1:0] dec_cidx;
    logic [ADDR_W-1:0] dec_off;
    logic [ADDR_W-1:0] ctrl_off;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;

    // Registered state
    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        kind_q, kind_d;
    logic [RIDX_W-1:0] ridx_q, ridx_d;
    logic [CIDX_W-1:0] cidx_q, cidx_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [NUM_REGIONS-1:0] reg_en_q, reg_en_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [DATA_W-1:0] ctrl_q [NUM_CTRL];
    logic [DATA_W-1:0] ctrl_d [NUM_CTRL];
    logic              vb_q, vb_d;
    logic              um_q, um_d;
    logic              irq_q, irq_d;
    logic              vblank_q, vblank_d;

    logic              vb_rise;
    logic              clr_vb;
    logic              clr_um;
    logic              um_set;
    logic [DATA_W-1:0] status_d;

    // Decode the live address into region / control / unmapped
    always_comb begin
        dec_kind = KIND_UNMAP;
        dec_ridx = '0;
        dec_cidx = '0;
        dec_off  = '0;
        lo       = '0;
        hi       = '0;
        ctrl_off = addr - CTRL_BASE;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            lo = BOUNDS[i*ADDR_W +: ADDR_W];
            hi = BOUNDS[(i+1)*ADDR_W +: ADDR_W];
            if (addr >= lo && addr < hi) begin
                dec_kind = KIND_REGION;
                dec_ridx = RIDX_W'(i);
                dec_off  = addr - lo;
            end
        end
        if (addr >= CTRL_BASE && ctrl_off < CTRL_SPAN) begin
            dec_kind = KIND_CTRL;
            dec_cidx = CIDX_W'(ctrl_off);
        end
    end

    // Transaction FSM, control registers and sticky status next-state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        ridx_d      = ridx_q;
        cidx_d      = cidx_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        reg_en_d    = '0;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        ctrl_d      = ctrl_q;
        clr_vb      = 1'b0;
        clr_um      = 1'b0;
        um_set      = 1'b0;
        vblank_d    = vblank;
        vb_rise     = vblank & ~vblank_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_ISSUE;
                    kind_d      = dec_kind;
                    ridx_d      = dec_ridx;
                    cidx_d      = dec_cidx;
                    we_d        = we;
                    reg_wdata_d = wdata;
                    reg_addr_d  = dec_off;
                    if (dec_kind == KIND_REGION) begin
                        reg_en_d[dec_ridx] = 1'b1;
                        reg_we_d           = we;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
                case (kind_q)
                    KIND_REGION: begin
                        if (!we_q) begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                    KIND_CTRL: begin
                        if (we_q) begin
                            if (cidx_q == '0) begin
                                clr_vb = reg_wdata_q[1];
                                clr_um = reg_wdata_q[0];
                            end else begin
                                ctrl_d[int'(cidx_q)] = reg_wdata_q;
                            end
                        end else begin
                            rdata_d = ctrl_q[int'(cidx_q)];
                        end
                    end
                    default: begin
                        um_set = 1'b1;
                        if (!we_q) begin
                            rdata_d = '0;
                        end
                    end
                endcase
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = reg_rdata[int'(ridx_q)*DATA_W +: DATA_W];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
                err_d   = (kind_q == KIND_UNMAP);
            end
        endcase

        // A vblank rise in the same cycle as a clearing write keeps VB set
        vb_d = (vb_q & ~clr_vb) | vb_rise;
        um_d = (um_q & ~clr_um) | um_set;

        status_d     = '0;
        status_d[15] = hblank;
        status_d[14] = vblank;
        status_d[1]  = vb_d;
        status_d[0]  = um_d;
        ctrl_d[0]    = status_d;

        irq_d  = vb_d & ctrl_d[1][15];
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            kind_q      <= KIND_UNMAP;
            ridx_q      <= '0;
            cidx_q      <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            reg_en_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= '0;
            end
            vb_q        <= 1'b0;
            um_q        <= 1'b0;
            irq_q       <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            ridx_q      <= ridx_d;
            cidx_q      <= cidx_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            reg_en_q    <= reg_en_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            vb_q        <= vb_d;
            um_q        <= um_d;
            irq_q       <= irq_d;
            vblank_q    <= vblank_d;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign reg_en    = reg_en_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign irq       = irq_q;

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

endmodule

// File: tb/tb_mmio_controller.sv
// tb/tb_mmio_controller.sv - randomized self-checking bench for mmio_controller
module tb_mmio_controller;

    localparam int RD_LAT = 2;
    localparam logic [15:0] TB_BASE [4] = '{16'h0000, 16'h2000, 16'h2400, 16'h4400};

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [3:0]  reg_en;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [15:0] reg_wdata;
    logic [63:0] reg_rdata;
    logic        hblank;
    logic        vblank;
    logic [63:0] ctrl_out;
    logic        irq;

    int checks;
    int failures;

    mmio_controller #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .reg_en(reg_en),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .hblank(hblank), .vblank(vblank),
        .ctrl_out(ctrl_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Region RAM device: sparse memory with RD_LAT read pipeline, garbage when idle
    logic [15:0] dev_mem [int];
    logic [15:0] pipe [4][RD_LAT];

    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int abs_a;
            abs_a = int'(TB_BASE[i]) + int'(reg_addr);
            for (int s = RD_LAT - 1; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
            if (reg_en[i] && !reg_we)
                pipe[i][0] <= dev_mem.exists(abs_a) ? dev_mem[abs_a] : mem_init(16'(abs_a));
            else
                pipe[i][0] <= 16'($urandom);
            if (reg_en[i] && reg_we) dev_mem[abs_a] = reg_wdata;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign reg_rdata[g*16 +: 16] = pipe[g][RD_LAT-1];
    end

    // Reference model: memory map semantics
    logic [15:0] ref_mem [int];
    logic [15:0] ref_ctrl [4];
    logic        ref_vb;
    logic        ref_um;

    // kind: 0 region, 1 control, 2 unmapped
    function automatic void ref_decode(input logic [15:0] a, output int kind, output int idx);
        kind = 2; idx = 0;
        if (a < 16'h2000)      begin kind = 0; idx = 0; end
        else if (a < 16'h2400) begin kind = 0; idx = 1; end
        else if (a < 16'h4400) begin kind = 0; idx = 2; end
        else if (a < 16'h4800) begin kind = 0; idx = 3; end
        else if (a < 16'h4804) begin kind = 1; idx = int'(a - 16'h4800); end
    endfunction

    function automatic logic [15:0] ref_status();
        return {hblank, vblank, 12'h000, ref_vb, ref_um};
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        int kind, idx;
        ref_decode(a, kind, idx);
        if (kind == 0) return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
        if (kind == 1) return (idx == 0) ? ref_status() : ref_ctrl[idx];
        return 16'h0000;
    endfunction

    task automatic ref_apply(input logic w, input logic [15:0] a, input logic [15:0] d);
        int kind, idx;
        ref_decode(a, kind, idx);
        if (kind == 2) ref_um = 1'b1;
        else if (w && kind == 0) ref_mem[int'(a)] = d;
        else if (w && kind == 1) begin
            if (idx == 0) begin
                if (d[1]) ref_vb = 1'b0;
                if (d[0]) ref_um = 1'b0;
            end else ref_ctrl[idx] = d;
        end
    endtask

    task automatic ref_reset();
        for (int k = 0; k < 4; k++) ref_ctrl[k] = 16'h0000;
        ref_vb = 1'b0;
        ref_um = 1'b0;
    endtask

    // Drive one request and observe it until ack (lat = -1 when no ack arrives)
    task automatic bus_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              output logic [15:0] rd, output logic e, output int lat,
                              output logic [3:0] en_seen, output int en_cycles,
                              output logic [15:0] off_seen, output logic we_seen);
        rd = '0; e = 1'b0; lat = -1; en_seen = '0; en_cycles = 0; off_seen = '0; we_seen = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (reg_en != 4'b0000) begin
                en_seen |= reg_en; en_cycles++; off_seen = reg_addr; we_seen = reg_we;
            end
            @(posedge clk); #1;
            if (ack) begin
                lat = k; rd = rdata; e = err;
                break;
            end
        end
    endtask

    logic [15:0] t_rd;
    logic        t_e;
    int          t_lat;
    logic [3:0]  t_en;
    int          t_enc;
    logic [15:0] t_off;
    logic        t_we;

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; hblank = 1'b0; vblank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (reg_en !== 4'b0000) begin failures++; $display("FAIL reset_reg_en got=%b exp=0000", reg_en); end
        checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if (ctrl_out !== 64'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_out); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk);
        rst = 1'b0;
        ref_reset();
    endtask

    task automatic test_ctrl();
        bus_access(1'b1, 16'h4802, 16'h00A5, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b1, 16'h4802, 16'h00A5);
        checks++; if (t_lat != 2) begin failures++; $display("FAIL ctrl_wr_lat got=%0d exp=2", t_lat); end
        checks++; if (ctrl_out[32 +: 16] !== 16'h00A5) begin failures++; $display("FAIL ctrl_wr_val got=%h exp=00a5", ctrl_out[32 +: 16]); end
        bus_access(1'b0, 16'h4802, 16'h0000, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        checks++; if (t_lat != 2) begin failures++; $display("FAIL ctrl_rd_lat got=%0d exp=2", t_lat); end
        checks++; if (t_rd !== 16'h00A5) begin failures++; $display("FAIL ctrl_rd_data got=%h exp=00a5", t_rd); end
        checks++; if (t_e !== 1'b0) begin failures++; $display("FAIL ctrl_rd_err got=%b exp=0", t_e); end
    endtask

    task automatic test_region_read();
        dev_mem[32'h2010] = 16'hBEEF;
        ref_mem[32'h2010] = 16'hBEEF;
        bus_access(1'b0, 16'h2010, 16'h0000, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        checks++; if (t_en !== 4'b0010 || t_enc != 1) begin failures++; $display("FAIL rgn_en got=%b/%0d exp=0010/1", t_en, t_enc); end
        checks++; if (t_off !== 16'h0010) begin failures++; $display("FAIL rgn_addr got=%h exp=0010", t_off); end
        checks++; if (t_lat != 2 + RD_LAT) begin failures++; $display("FAIL rgn_lat got=%0d exp=%0d", t_lat, 2 + RD_LAT); end
        checks++; if (t_rd !== 16'hBEEF) begin failures++; $display("FAIL rgn_data got=%h exp=beef", t_rd); end
    endtask

    task automatic test_unmapped();
        bus_access(1'b1, 16'h4810, 16'h1234, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b1, 16'h4810, 16'h1234);
        checks++; if (t_lat != 2 || t_e !== 1'b1) begin failures++; $display("FAIL unm_ack_err got=%0d/%b exp=2/1", t_lat, t_e); end
        checks++; if (t_enc != 0) begin failures++; $display("FAIL unm_no_en got=%0d exp=0", t_enc); end
        checks++; if (ctrl_out[0] !== 1'b1) begin failures++; $display("FAIL unm_status got=%b exp=1", ctrl_out[0]); end
        bus_access(1'b0, 16'hFFFF, 16'h0000, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b0, 16'hFFFF, 16'h0000);
        checks++; if (t_rd !== 16'h0000 || t_e !== 1'b1) begin failures++; $display("FAIL unm_rd got=%h/%b exp=0000/1", t_rd, t_e); end
    endtask

    task automatic test_vblank();
        int k;
        bus_access(1'b1, 16'h4801, 16'h8000, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b1, 16'h4801, 16'h8000);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL vb_irq_idle got=%b exp=0", irq); end
        @(negedge clk); vblank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ref_vb = 1'b1;
        checks++; if (ctrl_out[1] !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL vb_rise got=%b/%b exp=1/1", ctrl_out[1], irq); end
        @(negedge clk); vblank = 1'b0;
        repeat (3) @(posedge clk);
        // Status clear whose ISSUE-ending edge coincides with a new vblank rise
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h4800; wdata = 16'h0002;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk); vblank = 1'b1;
        k = 0;
        while (k < 10 && ack !== 1'b1) begin
            @(posedge clk); #1; k++;
        end
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL vb_coinc_ack got=%b exp=1", ack); end
        ref_apply(1'b1, 16'h4800, 16'h0002);
        ref_vb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ctrl_out[1] !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL vb_set_wins got=%b/%b exp=1/1", ctrl_out[1], irq); end
        @(negedge clk); vblank = 1'b0;
        bus_access(1'b1, 16'h4800, 16'h0002, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b1, 16'h4800, 16'h0002);
        checks++; if (ctrl_out[1:0] !== 2'b01 || irq !== 1'b0) begin failures++; $display("FAIL vb_clear got=%b/%b exp=01/0", ctrl_out[1:0], irq); end
    endtask

    task automatic check_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
        int kind, idx, exp_lat;
        logic [15:0] exp_rd;
        ref_decode(a, kind, idx);
        exp_rd  = ref_read(a);
        exp_lat = (kind == 0 && !w) ? 2 + RD_LAT : 2;
        bus_access(w, a, d, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(w, a, d);
        checks++; if (t_lat != exp_lat) begin failures++; $display("FAIL rnd_lat a=%h w=%b got=%0d exp=%0d", a, w, t_lat, exp_lat); end
        checks++; if (t_e !== (kind == 2)) begin failures++; $display("FAIL rnd_err a=%h got=%b exp=%b", a, t_e, kind == 2); end
        if (!w) begin
            checks++; if (t_rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata a=%h got=%h exp=%h", a, t_rd, exp_rd); end
        end
        if (kind == 0) begin
            checks++;
            if (t_en !== 4'(1 << idx) || t_enc != 1 || t_off !== a - TB_BASE[idx] || t_we !== w) begin
                failures++;
                $display("FAIL rnd_region a=%h got=%b/%0d/%h/%b exp=%b/1/%h/%b", a, t_en, t_enc, t_off, t_we, 4'(1 << idx), a - TB_BASE[idx], w);
            end
        end else begin
            checks++; if (t_enc != 0) begin failures++; $display("FAIL rnd_no_en a=%h got=%0d exp=0", a, t_enc); end
        end
        for (int k = 1; k < 4; k++) begin
            checks++; if (ctrl_out[k*16 +: 16] !== ref_ctrl[k]) begin failures++; $display("FAIL rnd_ctrl%0d got=%h exp=%h", k, ctrl_out[k*16 +: 16], ref_ctrl[k]); end
        end
        checks++; if (ctrl_out[15:0] !== ref_status()) begin failures++; $display("FAIL rnd_status got=%h exp=%h", ctrl_out[15:0], ref_status()); end
        checks++; if (irq !== (ref_vb & ref_ctrl[1][15])) begin failures++; $display("FAIL rnd_irq got=%b exp=%b", irq, ref_vb & ref_ctrl[1][15]); end
    endtask

    task automatic test_random();
        logic [15:0] edges [10] = '{16'h1FFF, 16'h2000, 16'h23FF, 16'h2400, 16'h43FF,
                                    16'h4400, 16'h47FF, 16'h4800, 16'h4803, 16'h4804};
        logic [15:0] a;
        int sel;
        for (int n = 0; n < 10; n++) begin
            check_txn(1'($urandom), edges[n], 16'($urandom));
            check_txn(1'b0, edges[n], 16'h0000);
        end
        for (int n = 0; n < 60; n++) begin
            hblank = 1'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0: a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1: a = 16'($urandom_range(16'h2000, 16'h23FF));
                2: a = 16'($urandom_range(16'h2400, 16'h43FF));
                3: a = 16'($urandom_range(16'h4400, 16'h47FF));
                4: a = 16'h4800 + 16'($urandom_range(0, 3));
                default: a = 16'($urandom_range(16'h4804, 16'hFFFF));
            endcase
            check_txn(1'($urandom), a, 16'($urandom));
        end
        hblank = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks;
        bus_access(1'b1, 16'h4802, 16'h1234, t_rd, t_e, t_lat, t_en, t_enc, t_off, t_we);
        ref_apply(1'b1, 16'h4802, 16'h1234);
        checks++; if (ctrl_out[32 +: 16] !== 16'h1234) begin failures++; $display("FAIL rstm_pre got=%h exp=1234", ctrl_out[32 +: 16]); end
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0100;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstm_busy_wait got=%b exp=1", busy); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        ref_reset();
        checks++; if (busy !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL rstm_abort got=%b/%b exp=0/0", busy, ack); end
        checks++; if (ctrl_out !== 64'h0) begin failures++; $display("FAIL rstm_ctrl got=%h exp=0", ctrl_out); end
        @(negedge clk); rst = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL rstm_no_ack got=%0d exp=0", acks); end
        check_txn(1'b0, 16'h4802, 16'h0000);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_ctrl();
        test_region_read();
        test_unmapped();
        test_vblank();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_controller.md
MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: bus address width.
REQ-002 SHALL have parameter DATA_W, default 16: bus data width.
REQ-003 SHALL have parameter NUM_REGIONS, default 4: number of external RAM regions.
REQ-004 SHALL have parameter REGION_BASE, default {16'h4400,16'h2400,16'h2000,16'h0000}: flattened ascending region bases, region 0 in the LSBs.
REQ-005 SHALL have parameter CTRL_BASE, default 16'h4800: control window base, which is also the upper bound of the last region.
REQ-006 SHALL have parameter NUM_CTRL, default 4: control words; index 0 is status, indices 1..NUM_CTRL-1 are R/W.
REQ-007 SHALL have parameter RD_LAT, default 1, legal range 1..4: region RAM read latency.
REQ-008 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  write when 1.
- addr  in  ADDR_W  byte-free word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, held until the next ack.
- ack  out  1  one-cycle completion pulse.
- err  out  1  pulses with ack on an unmapped access.
- busy  out  1  high when state != IDLE.
- reg_en  out  NUM_REGIONS  one-hot region enable.
- reg_we  out  1  region write enable.
- reg_addr  out  ADDR_W  offset, addr - REGION_BASE[i].
- reg_wdata  out  DATA_W  region write data.
- reg_rdata  in  NUM_REGIONS*DATA_W  flattened region read data.
- hblank  in  1  live video status.
- vblank  in  1  live video status.
- ctrl_out  out  NUM_CTRL*DATA_W  flattened control words; index 0 is the status image.
- irq  out  1  vblank interrupt.

Function
REQ-009 Decode SHALL hit region i when REGION_BASE[i] <= addr < next base (CTRL_BASE for the last region).
REQ-010 Decode SHALL hit the control window when CTRL_BASE <= addr < CTRL_BASE+NUM_CTRL.
REQ-011 Any other address SHALL decode as unmapped.
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; all outputs are registered.
REQ-013 IDLE SHALL go to ISSUE when req=1, capturing addr, we, wdata and the decode result; req is ignored in every other state.
REQ-014 ISSUE SHALL last one cycle; a region hit asserts reg_en[i] only in that cycle, with reg_we=we and reg_addr/reg_wdata valid.
REQ-015 ISSUE SHALL go to WAIT for a region read; it goes to DONE for any write, control access or unmapped access.
REQ-016 WAIT SHALL last exactly RD_LAT cycles, driven by a down-counter; on its final edge rdata captures slice i of reg_rdata, then the FSM enters DONE.
REQ-017 DONE SHALL assert ack for one cycle and return to IDLE; a req present in the cycle after DONE is accepted.
REQ-018 Latency from the acceptance edge to ack SHALL be 2 cycles for writes, control and unmapped accesses, and 2+RD_LAT cycles for region reads.
REQ-019 A control write to index k>=1 SHALL update ctrl_out[k] on the edge ending ISSUE.
REQ-020 A control read SHALL return the current word, sampled in ISSUE.
REQ-021 The status word SHALL be: bit15 = hblank, bit14 = vblank, bit1 = VB sticky, bit0 = UM sticky; all other bits read 0.
REQ-022 VB SHALL set on a vblank rising edge, detected against a registered copy of vblank.
REQ-023 UM SHALL set on any unmapped access in ISSUE.
REQ-024 Writing status SHALL clear each sticky bit written with 1 (write-1-to-clear); if set and clear coincide, set wins.
REQ-025 irq SHALL equal VB AND ctrl_out[1] bit 15, registered.
REQ-026 An unmapped access SHALL pulse err with ack; an unmapped write has no other effect, and an unmapped read returns 0.
REQ-027 reg_en SHALL never have more than one bit set and SHALL be 0 outside ISSUE.

Reset
REQ-028 While rst=1 on a clock edge, the block SHALL force state=IDLE, ack=0, err=0, busy=0, reg_en=0, reg_we=0, rdata=0, all ctrl words=0, VB=UM=0, irq=0 and the vblank history=0.
REQ-029 A reset mid-transaction SHALL abort the transaction with no ack, no pending write, and no ctrl update unless ISSUE had already completed.

Verification
REQ-030 Write 0x4802=0x00A5, then read 0x4802 -> ctrl_out[2]=0x00A5; each ack is 2 cycles after acceptance; the read returns 0x00A5 with err=0.
REQ-031 With RD_LAT=2, read 0x2010 with reg_rdata slice 1=0xBEEF -> reg_en=4'b0010 and reg_addr=0x0010 for one cycle; ack comes 4 cycles after acceptance with rdata=0xBEEF.
REQ-032 Write 0x4810 (unmapped) -> ack and err pulse together, status bit0=1, and no reg_en activity.
REQ-033 Write ctrl1=0x8000, then raise vblank -> VB=1 and irq=1.
REQ-034 Continuing from REQ-033, write status=0x0002 in the same cycle as a new vblank rise -> VB stays 1; a later write with no rise clears VB and irq.
REQ-035 Assert rst during WAIT -> no ack, busy=0 next cycle, and all ctrl_out words=0.
